// File: rtl/key_pkg.sv
// Shared definitions for the push-button conditioner: channel state encoding,
// counter sizing helper and the 100 MHz default timing constants.
package key_pkg;

    typedef logic [1:0] key_state_t;

    localparam key_state_t ST_RELEASED     = 2'd0;
    localparam key_state_t ST_PRESS_PEND   = 2'd1;
    localparam key_state_t ST_PRESSED      = 2'd2;
    localparam key_state_t ST_RELEASE_PEND = 2'd3;

    localparam int DEF_N_KEYS          = 3;
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_REPEAT_EN       = 0;
    localparam int DEF_REPEAT_DELAY    = 50000000;
    localparam int DEF_REPEAT_PERIOD   = 10000000;

    // Width that holds the largest terminal value among all the timers.
    function automatic int cnt_width(input int debounce, input int delay, input int period);
        int m;
        m = debounce;
        if (delay > m) m = delay;
        if (period > m) m = period;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// One key channel: two-flop synchroniser, debounce FSM with registered
// press/release strobes, and an optional auto-repeat timer.
module key_debounce_channel
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_EN       = DEF_REPEAT_EN,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk100_i,
    input  logic rstn_i,
    input  logic key_i,
    output logic pressed_o,
    output logic down_o,
    output logic up_o
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    key_state_t    state;
    logic [CW-1:0] cnt;
    logic          rpt_fire;

    // Synchroniser resets to the released (high) level so no false press follows reset.
    always_ff @(posedge clk100_i or negedge rstn_i) begin
        if (!rstn_i) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= key_i;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk100_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state     <= ST_RELEASED;
            cnt       <= '0;
            pressed_o <= 1'b0;
            down_o    <= 1'b0;
            up_o      <= 1'b0;
        end else begin
            down_o <= 1'b0;
            up_o   <= 1'b0;
            case (state)
                ST_RELEASED: begin
                    if (!s2) begin
                        state <= ST_PRESS_PEND;
                        cnt   <= CW'(1);
                    end
                end
                ST_PRESS_PEND: begin
                    if (s2) begin
                        state <= ST_RELEASED;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state     <= ST_PRESSED;
                        cnt       <= '0;
                        down_o    <= 1'b1;
                        pressed_o <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_PRESSED: begin
                    if (s2) begin
                        state <= ST_RELEASE_PEND;
                        cnt   <= CW'(1);
                    end else if (rpt_fire) begin
                        down_o <= 1'b1;
                    end
                end
                ST_RELEASE_PEND: begin
                    if (!s2) begin
                        state <= ST_PRESSED;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state     <= ST_RELEASED;
                        cnt       <= '0;
                        up_o      <= 1'b1;
                        pressed_o <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= ST_RELEASED;
                    cnt   <= '0;
                end
            endcase
        end
    end

    if (REPEAT_EN != 0) begin : g_repeat
        logic [CW-1:0] rpt;
        logic          rpt_phase;
        logic [CW-1:0] rpt_last;

        // The first terminal is the initial delay; after the first repeat it is the period.
        assign rpt_last = rpt_phase ? CW'(REPEAT_PERIOD - 1) : CW'(REPEAT_DELAY - 1);
        assign rpt_fire = (state == ST_PRESSED) && !s2 && (rpt == rpt_last);

        always_ff @(posedge clk100_i or negedge rstn_i) begin
            if (!rstn_i) begin
                rpt       <= '0;
                rpt_phase <= 1'b0;
            end else if (state == ST_PRESSED) begin
                if (!s2) begin
                    if (rpt == rpt_last) begin
                        rpt       <= '0;
                        rpt_phase <= 1'b1;
                    end else begin
                        rpt <= rpt + CW'(1);
                    end
                end
            end else begin
                rpt <= '0;
                if (state != ST_RELEASE_PEND) rpt_phase <= 1'b0;
            end
        end
    end else begin : g_no_repeat
        assign rpt_fire = 1'b0;
    end

endmodule

// File: rtl/key_debouncer.sv
// Board push-button conditioner: one independent debounce channel per key,
// giving a clean held level plus press/release strobes to the datapath.
module key_debouncer
    import key_pkg::*;
#(
    parameter int N_KEYS          = DEF_N_KEYS,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_EN       = DEF_REPEAT_EN,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic              clk100_i,
    input  logic              rstn_i,
    input  logic [N_KEYS-1:0] key_i,
    output logic [N_KEYS-1:0] pressed_o,
    output logic [N_KEYS-1:0] down_o,
    output logic [N_KEYS-1:0] up_o
);

    for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
        key_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_EN       (REPEAT_EN),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_chan (
            .clk100_i  (clk100_i),
            .rstn_i    (rstn_i),
            .key_i     (key_i[i]),
            .pressed_o (pressed_o[i]),
            .down_o    (down_o[i]),
            .up_o      (up_o[i])
        );
    end

endmodule
